// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the fetch stage and the
// instruction port of main memory. Hits return combinationally; a miss stalls
// the CPU, fills the whole line one word per qualified MEM_VALID1 rising edge,
// spends one REPLAY cycle, and then lets the lookup hit.
// Optional build macro ICACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT.
module icache_dm #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    input  logic        CPU_RDEN,
    output logic [31:0] INSTR,
    output logic        STALL,
    output logic        HIT,
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        MEM_VALID1
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] HIT_COUNT,
    output logic [31:0] MISS_COUNT
`endif
);

    localparam int TAG_BITS = 14 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << (INDEX_BITS + OFFSET_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_REPLAY
    } state_t;

    // Word-address split of the fetch PC; byte offset and upper bits are unused.
    logic [OFFSET_BITS-1:0] pc_offset;
    logic [INDEX_BITS-1:0]  pc_index;
    logic [TAG_BITS-1:0]    pc_tag;
    logic                   pc_unused;

    assign pc_offset = PC[2 +: OFFSET_BITS];
    assign pc_index  = PC[2 + OFFSET_BITS +: INDEX_BITS];
    assign pc_tag    = PC[15 -: TAG_BITS];
    assign pc_unused = ^{PC[31:16], PC[1:0]};

    // Storage
    logic [31:0]         data_mem [WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid_q;

    // Control state
    state_t                 state_q, state_d;
    logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;
    logic [INDEX_BITS-1:0]  miss_index_q, miss_index_d;
    logic [OFFSET_BITS-1:0] word_cnt_q, word_cnt_d;
    logic                   armed_q, armed_d;
    logic                   valid_prev_q;

    // Combinational outputs before reset gating
    logic        hit_c;
    logic        stall_c;
    logic        rden_c;
    logic [31:0] instr_c;
    logic [13:0] addr_c;
    logic        accept_c;
    logic        last_word_c;

    // Lookup, miss detection, fill sequencing and next-state selection.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        word_cnt_d   = word_cnt_q;
        armed_d      = armed_q;
        hit_c        = 1'b0;
        stall_c      = 1'b0;
        rden_c       = 1'b0;
        instr_c      = '0;
        addr_c       = '0;
        accept_c     = 1'b0;
        last_word_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hit_c = CPU_RDEN && valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);
                if (hit_c) begin
                    instr_c = data_mem[{pc_index, pc_offset}];
                end else if (CPU_RDEN) begin
                    stall_c      = 1'b1;
                    miss_tag_d   = pc_tag;
                    miss_index_d = pc_index;
                    word_cnt_d   = '0;
                    armed_d      = 1'b0;
                    state_d      = ST_FILL;
                end
            end
            ST_FILL: begin
                stall_c = 1'b1;
                rden_c  = 1'b1;
                addr_c  = {miss_tag_q, miss_index_q, word_cnt_q};
                // Capture only on a rising valid edge seen after the address
                // has been held for a full cycle; stale high levels are ignored.
                accept_c    = armed_q && MEM_VALID1 && !valid_prev_q;
                last_word_c = accept_c && (word_cnt_q == '1);
                if (accept_c) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    armed_d    = 1'b0;
                    if (last_word_c) begin
                        state_d = ST_REPLAY;
                    end
                end else begin
                    armed_d = 1'b1;
                end
            end
            ST_REPLAY: begin
                stall_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs read as idle while reset is held, even with a request pending.
    assign HIT       = RST ? 1'b0  : hit_c;
    assign STALL     = RST ? 1'b0  : stall_c;
    assign INSTR     = RST ? '0    : instr_c;
    assign MEM_RDEN1 = RST ? 1'b0  : rden_c;
    assign MEM_ADDR1 = RST ? '0    : addr_c;

    // Control registers and per-line valid bits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            word_cnt_q   <= '0;
            armed_q      <= 1'b0;
            valid_prev_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values regardless of order.
            state_q      <= state_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            word_cnt_q   <= word_cnt_d;
            armed_q      <= armed_d;
            valid_prev_q <= MEM_VALID1;
            if (last_word_c) begin
                valid_q[miss_index_q] <= 1'b1;
            end
        end
    end

    // Line fill writes into the data and tag arrays.
    always_ff @(posedge CLK) begin
        // NOTE: the arrays have no reset; the valid bits alone qualify their contents.
        if (accept_c) begin
            data_mem[{miss_index_q, word_cnt_q}] <= MEM_DOUT1;
        end
        if (last_word_c) begin
            tag_mem[miss_index_q] <= miss_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Saturating hit and miss counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit_c && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == ST_IDLE) && (state_d == ST_FILL) && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`endif

endmodule
